// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter shared by the instruction fetcher (IF) and the
// load/store unit (LS). Multi-byte accesses are issued as consecutive byte
// cycles and reads are reassembled little-endian.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_clr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    // state | meaning
    // IDLE  | arbitrate and latch the granted request
    // XFER  | one byte address per cycle, cnt = byte index
    // FLUSH | reads only: collect the last byte, which lags its address by a cycle
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_FLUSH} state_t;

    state_t              state, state_nx;
    logic                own_ls, last_ls, wr, if_abort;
    logic                if_done_q, ls_done_q;
    logic [ADDR_W-1:0]   addr;
    logic [1:0]          cnt, cnt_m1, last_idx, size_last;
    logic [DATA_W-1:0]   wdata, rbuf, rbuf_full;
    logic                if_elig, ls_elig, grant_if, grant_ls, contested, last_byte;

    assign size_last = (ls_size == 2'b00) ? 2'd0 :
                       (ls_size == 2'b01) ? 2'd1 : 2'd3;
    assign cnt_m1    = cnt - 2'd1;

    // Done pulses are only visible while the block is enabled.
    assign if_done = if_done_q & rdy;
    assign ls_done = ls_done_q & rdy;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else if (rdy)
            state <= state_nx;
    end

    // Arbitration and next-state logic.
    always_comb begin
        state_nx  = state;
        grant_ls  = 1'b0;
        grant_if  = 1'b0;
        contested = 1'b0;
        if_elig   = if_req & ~if_clr & ~if_done_q;
        ls_elig   = ls_req & ~ls_done_q;
        last_byte = (cnt == last_idx);
        case (state)
            S_IDLE: begin
                contested = if_elig & ls_elig;
                grant_ls  = ls_elig & (~if_elig | ~last_ls);
                grant_if  = if_elig & ~grant_ls;
                if (grant_ls || grant_if)
                    state_nx = S_XFER;
            end
            S_XFER: begin
                if (last_byte)
                    state_nx = wr ? S_IDLE : S_FLUSH;
            end
            S_FLUSH: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // RAM port drive. While stalled mid-read the previous byte address is
    // re-presented so mem_din still carries the byte captured on resume.
    always_comb begin
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = '0;
        case (state)
            S_XFER: begin
                if (rdy || cnt == 2'd0)
                    mem_a = addr + ADDR_W'(cnt);
                else
                    mem_a = addr + ADDR_W'(cnt_m1);
                mem_wr = wr & rdy;
                if (wr)
                    mem_dout = wdata[{cnt, 3'b000} +: 8];
            end
            S_FLUSH: mem_a = addr + ADDR_W'(last_idx);
            default: ;
        endcase
    end

    // Read word with the final byte merged in straight from the RAM.
    always_comb begin
        rbuf_full = rbuf;
        rbuf_full[{last_idx, 3'b000} +: 8] = mem_din;
    end

    // Transaction registers, byte capture and done pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own_ls    <= 1'b0;
            last_ls   <= 1'b1;
            wr        <= 1'b0;
            if_abort  <= 1'b0;
            addr      <= '0;
            cnt       <= '0;
            last_idx  <= '0;
            wdata     <= '0;
            rbuf      <= '0;
            if_data   <= '0;
            ls_rdata  <= '0;
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
        end else if (rdy) begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_if || grant_ls) begin
                        own_ls   <= grant_ls;
                        addr     <= grant_ls ? ls_addr : if_addr;
                        wr       <= grant_ls & ls_wr;
                        last_idx <= grant_ls ? size_last : 2'd3;
                        wdata    <= grant_ls ? ls_wdata : '0;
                        rbuf     <= '0;
                        cnt      <= '0;
                        if_abort <= 1'b0;
                        // Round-robin pointer only moves on a genuine conflict.
                        if (contested)
                            last_ls <= grant_ls;
                    end
                end
                S_XFER: begin
                    cnt <= cnt + 2'd1;
                    if (!wr && cnt != 2'd0)
                        rbuf[{cnt_m1, 3'b000} +: 8] <= mem_din;
                    if (!own_ls && if_clr)
                        if_abort <= 1'b1;
                    if (last_byte && wr)
                        ls_done_q <= 1'b1;
                end
                S_FLUSH: begin
                    if (own_ls) begin
                        ls_rdata  <= rbuf_full;
                        ls_done_q <= 1'b1;
                    end else if (!(if_abort || if_clr)) begin
                        if_data   <= rbuf_full;
                        if_done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural byte RAM.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_clr = 1'b0;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req = 1'b0;
    logic        ls_wr = 1'b0;
    logic [1:0]  ls_size = '0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    logic [31:0] wr_a = '0;
    logic [7:0]  wr_d = '0;
    int          wr_base;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_clr(if_clr),
        .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h100:  return 8'h13;
            32'h101:  return 8'h05;
            32'h200:  return 8'h11;
            32'h201:  return 8'h22;
            32'h202:  return 8'h33;
            32'h203:  return 8'h44;
            32'h2002: return 8'hCD;
            32'h2003: return 8'hAB;
            default:  return 8'h00;
        endcase
    endfunction

    // RAM: registered read, writes logged for checking.
    always @(posedge clk) begin
        mem_din <= rom(mem_a);
        if (mem_wr) begin
            wr_cnt <= wr_cnt + 1;
            wr_a   <= mem_a;
            wr_d   <= mem_dout;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit port_ls, input string tag);
        int n;
        n = 0;
        while (n < 30 && !(port_ls ? ls_done : if_done)) begin
            step();
            n++;
        end
        check_eq(tag, 32'(port_ls ? ls_done : if_done), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        // reset state
        #2;
        check_eq("rst_mem_a", mem_a, 32'h0);
        check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("rst_mem_dout", 32'(mem_dout), 32'd0);
        check_eq("rst_if_done", 32'(if_done), 32'd0);
        check_eq("rst_ls_done", 32'(ls_done), 32'd0);
        do_reset();

        // 1: IF word read at 0x100
        if_req = 1'b1; if_addr = 32'h100;
        step();
        check_eq("t1_a0", mem_a, 32'h100);
        check_eq("t1_wr", 32'(mem_wr), 32'd0);
        step(); check_eq("t1_a1", mem_a, 32'h101);
        step(); check_eq("t1_a2", mem_a, 32'h102);
        step(); check_eq("t1_a3", mem_a, 32'h103);
        step();
        check_eq("t1_flush_a", mem_a, 32'h103);
        check_eq("t1_early_done", 32'(if_done), 32'd0);
        step();
        check_eq("t1_done", 32'(if_done), 32'd1);
        check_eq("t1_data", if_data, 32'h0000_0513);
        if_req = 1'b0;
        step();
        check_eq("t1_pulse_end", 32'(if_done), 32'd0);

        // 2: LS byte write 0x1004
        wr_base = wr_cnt;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b00; ls_addr = 32'h1004; ls_wdata = 32'h1234_56AB;
        step();
        check_eq("t2_wr", 32'(mem_wr), 32'd1);
        check_eq("t2_a", mem_a, 32'h1004);
        check_eq("t2_dout", 32'(mem_dout), 32'hAB);
        check_eq("t2_early_done", 32'(ls_done), 32'd0);
        ls_wdata = 32'hFFFF_FFFF;
        step();
        check_eq("t2_done", 32'(ls_done), 32'd1);
        check_eq("t2_wr_off", 32'(mem_wr), 32'd0);
        check_eq("t2_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
        check_eq("t2_wr_d", 32'(wr_d), 32'hAB);
        ls_req = 1'b0; ls_wr = 1'b0;
        step();

        // 3: simultaneous requests from reset, then reversed on next conflict
        do_reset();
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b10; ls_addr = 32'h200;
        step();
        check_eq("t3_if_first", mem_a, 32'h100);
        wait_done(1'b0, "t3_if_done");
        check_eq("t3_if_data", if_data, 32'h0000_0513);
        if_req = 1'b0;
        step();
        check_eq("t3_ls_next", mem_a, 32'h200);
        wait_done(1'b1, "t3_ls_done");
        check_eq("t3_ls_data", ls_rdata, 32'h4433_2211);
        ls_req = 1'b0;
        step();
        if_req = 1'b1; ls_req = 1'b1;
        step();
        check_eq("t3_ls_first", mem_a, 32'h200);
        wait_done(1'b1, "t3_ls_done2");
        ls_req = 1'b0;
        step();
        check_eq("t3_if_second", mem_a, 32'h100);
        wait_done(1'b0, "t3_if_done2");
        if_req = 1'b0;
        step();

        // 4: LS half read 0x2002 with a 3-cycle stall
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b01; ls_addr = 32'h2002;
        step();
        check_eq("t4_a0", mem_a, 32'h2002);
        step();
        rdy = 1'b0;
        step();
        check_eq("t4_stall_wr", 32'(mem_wr), 32'd0);
        check_eq("t4_stall_done", 32'(ls_done), 32'd0);
        step();
        step();
        rdy = 1'b1;
        step();
        check_eq("t4_early_done", 32'(ls_done), 32'd0);
        step();
        check_eq("t4_done", 32'(ls_done), 32'd1);
        check_eq("t4_data", ls_rdata, 32'h0000_ABCD);
        ls_req = 1'b0;
        step();

        // 5: IF read aborted by if_clr at cnt 2; pending LS follows FLUSH
        if_req = 1'b1; if_addr = 32'h200;
        step();
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b00; ls_addr = 32'h2003;
        step();
        step();
        if_clr = 1'b1; if_req = 1'b0;
        step();
        if_clr = 1'b0;
        check_eq("t5_no_done_a", 32'(if_done), 32'd0);
        step();
        check_eq("t5_no_done_b", 32'(if_done), 32'd0);
        step();
        check_eq("t5_no_done_c", 32'(if_done), 32'd0);
        check_eq("t5_if_data_hold", if_data, 32'h0000_0513);
        step();
        check_eq("t5_ls_granted", mem_a, 32'h2003);
        wait_done(1'b1, "t5_ls_done");
        check_eq("t5_ls_data", ls_rdata, 32'h0000_00AB);
        ls_req = 1'b0;
        step();

        // 6: reset during LS word write at cnt 1
        wr_base = wr_cnt;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b10; ls_addr = 32'h3000; ls_wdata = 32'hDEAD_BEEF;
        step();
        step();
        rst = 1'b0;
        #1;
        check_eq("t6_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("t6_mem_a", mem_a, 32'h0);
        check_eq("t6_mem_dout", 32'(mem_dout), 32'd0);
        check_eq("t6_ls_done", 32'(ls_done), 32'd0);
        ls_req = 1'b0; ls_wr = 1'b0;
        step();
        rst = 1'b1;
        step();
        check_eq("t6_idle_a", mem_a, 32'h0);
        check_eq("t6_no_done", 32'(ls_done), 32'd0);
        check_eq("t6_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
        check_eq("t6_wr_a", wr_a, 32'h3000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
